// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU op classes, R-type funct codes,
// forwarding selects and the multiplier FSM state.
package ex_stage_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  // 2'b11 is not a real source and falls back to the ID/EX value.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle for
// DATA_W cycles, then one DONE cycle presenting the low DATA_W product bits.
module ex_stage_mul_iter
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o,
  output mul_state_e        state_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mul_state_e        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        // A zero multiplier still runs every step so latency never varies.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Combinational so the upstream registers freeze in the start cycle itself.
  assign busy_o    = start_i | (state_q == ST_MUL);
  assign done_o    = (state_q == ST_DONE);
  assign product_o = acc_q;
  assign state_o   = state_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, single-cycle ALU, destination select,
// and an iterative multiplier that stalls the front of the pipe while running.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] extend_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              RegDst_i,
  input  logic [REG_W-1:0]  MUX0_i,
  input  logic [REG_W-1:0]  MUX1_i,
  input  logic [1:0]        fwdA_i,
  input  logic [1:0]        fwdB_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_W-1:0]  wreg_o,
  output logic              busy_o
);

  // Stall contract: while busy_o is 1 the ID/EX register must hold this
  // instruction unchanged; the instruction leaves EX at the first rising edge
  // where valid_i=1 and busy_o=0, with result_o valid in that cycle.

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_bf;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [5:0]        funct;
  logic              is_mul;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  mul_state_e        mul_state;

  always_comb begin
    case (fwd_e'(fwdA_i))
      FWD_EXMEM: op_a = exmem_data_i;
      FWD_MEMWB: op_a = memwb_data_i;
      default:   op_a = data1_i;
    endcase
  end

  always_comb begin
    case (fwd_e'(fwdB_i))
      FWD_EXMEM: op_bf = exmem_data_i;
      FWD_MEMWB: op_bf = memwb_data_i;
      default:   op_bf = data2_i;
    endcase
  end

  assign op_b  = ALUSrc_i ? extend_i : op_bf;
  assign funct = extend_i[5:0];

  always_comb begin
    alu_res = '0;
    case (aluop_e'(ALUOp_i))
      ALUOP_ADD: alu_res = op_a + op_b;
      ALUOP_SUB: alu_res = op_a - op_b;
      ALUOP_OR:  alu_res = op_a | op_b;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_res = op_a + op_b;
          FUNCT_SUB: alu_res = op_a - op_b;
          FUNCT_AND: alu_res = op_a & op_b;
          FUNCT_OR:  alu_res = op_a | op_b;
          FUNCT_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default:   alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Only IDLE may launch; in DONE the same mul is still in ID/EX and must not restart.
  assign is_mul    = (aluop_e'(ALUOp_i) == ALUOP_RTYPE) && (funct == FUNCT_MUL);
  assign mul_start = valid_i && is_mul && (mul_state == ST_IDLE);

  ex_stage_mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_bf),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product),
    .state_o   (mul_state)
  );

  assign result_o     = mul_done ? mul_product : alu_res;
  assign store_data_o = op_bf;
  assign wreg_o       = RegDst_i ? MUX1_i : MUX0_i;
  assign busy_o       = mul_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: drivers push expected retirements into a queue,
// a negedge monitor pops and compares whenever an instruction leaves EX.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EXP_W  = 2*DATA_W + REG_W + 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [DATA_W-1:0] data1_i, data2_i, extend_i;
  logic              ALUSrc_i;
  logic [1:0]        ALUOp_i;
  logic              RegDst_i;
  logic [REG_W-1:0]  MUX0_i, MUX1_i;
  logic [1:0]        fwdA_i, fwdB_i;
  logic [DATA_W-1:0] exmem_data_i, memwb_data_i;
  logic [DATA_W-1:0] result_o, store_data_o;
  logic [REG_W-1:0]  wreg_o;
  logic              busy_o;

  ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .extend_i     (extend_i),
    .ALUSrc_i     (ALUSrc_i),
    .ALUOp_i      (ALUOp_i),
    .RegDst_i     (RegDst_i),
    .MUX0_i       (MUX0_i),
    .MUX1_i       (MUX1_i),
    .fwdA_i       (fwdA_i),
    .fwdB_i       (fwdB_i),
    .exmem_data_i (exmem_data_i),
    .memwb_data_i (memwb_data_i),
    .result_o     (result_o),
    .store_data_o (store_data_o),
    .wreg_o       (wreg_o),
    .busy_o       (busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_ret = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk_i) begin : monitor
    logic [EXP_W-1:0] e;
    if (rst_i === 1'b1 && valid_i === 1'b1 && busy_o === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_retire: got result 0x%08h expected no retirement (cycle %0d)",
                 result_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("t%0d_result", n_ret), result_o, e[100:69]);
        check($sformatf("t%0d_store", n_ret), store_data_o, e[68:37]);
        check($sformatf("t%0d_wreg", n_ret), {27'b0, wreg_o}, {27'b0, e[36:32]});
        check($sformatf("t%0d_retire_cycle", n_ret), 32'(cyc), e[31:0]);
        n_ret++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ops(input logic [1:0] aluop, input logic [31:0] ext, input logic src,
                         input logic [31:0] d1, input logic [31:0] d2);
    valid_i      = 1'b1;
    ALUOp_i      = aluop;
    extend_i     = ext;
    ALUSrc_i     = src;
    data1_i      = d1;
    data2_i      = d2;
    fwdA_i       = 2'b00;
    fwdB_i       = 2'b00;
    exmem_data_i = '0;
    memwb_data_i = '0;
    RegDst_i     = 1'b1;
    MUX0_i       = 5'd2;
    MUX1_i       = 5'd3;
  endtask

  task automatic issue_alu(input string name, input logic [31:0] res,
                           input logic [31:0] st, input logic [4:0] wr);
    exp_q.push_back({res, st, wr, 32'(cyc)});
    #1;
    check({name, "_busy"}, {31'b0, busy_o}, 32'd0);
    step();
  endtask

  // Holds the instruction as ID/EX would, counting busy cycles until release.
  task automatic issue_mul(input string name, input logic [31:0] res,
                           input logic [31:0] st, input bit toggle);
    int n;
    exp_q.push_back({res, st, 5'd3, 32'(cyc + 33)});
    n = 0;
    #1;
    while (busy_o === 1'b1 && n < 40) begin
      n++;
      step();
      if (toggle) data1_i = $urandom;
      #1;
    end
    check({name, "_busy_cycles"}, 32'(n), 32'd33);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b0;
    set_ops(2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
    valid_i = 1'b0;
    step();
    step();
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_state", {30'b0, dut.u_mul_iter.state_o}, {30'b0, ST_IDLE});
    rst_i = 1'b1;
    step();

    set_ops(2'b10, 32'h20, 1'b0, 32'd7, 32'd5);
    issue_alu("add_funct", 32'd12, 32'd5, 5'd3);
    set_ops(2'b10, 32'h2A, 1'b0, 32'hFFFF_FFFF, 32'd1);
    issue_alu("slt_neg", 32'd1, 32'd1, 5'd3);
    set_ops(2'b10, 32'h22, 1'b0, 32'd3, 32'd5);
    issue_alu("sub_funct", 32'hFFFF_FFFE, 32'd5, 5'd3);
    set_ops(2'b00, 32'd4, 1'b1, 32'hAAAA, 32'd9);
    fwdA_i = 2'b10; exmem_data_i = 32'h100;
    fwdB_i = 2'b01; memwb_data_i = 32'hDEAD_0000;
    RegDst_i = 1'b0; MUX0_i = 5'd7;
    issue_alu("fwd_imm", 32'h104, 32'hDEAD_0000, 5'd7);
    set_ops(2'b10, 32'h24, 1'b0, 32'hF0F0, 32'hFF00);
    issue_alu("and_funct", 32'hF000, 32'hFF00, 5'd3);
    set_ops(2'b11, 32'hF0, 1'b1, 32'h0F, 32'h1234);
    issue_alu("ori", 32'hFF, 32'h1234, 5'd3);
    set_ops(2'b01, 32'h0, 1'b0, 32'd50, 32'd1);
    fwdB_i = 2'b10; exmem_data_i = 32'd8;
    issue_alu("sub_fwdb", 32'd42, 32'd8, 5'd3);
    set_ops(2'b10, 32'h3F, 1'b0, 32'd1, 32'd1);
    issue_alu("bad_funct", 32'd0, 32'd1, 5'd3);
    set_ops(2'b00, 32'h0, 1'b0, 32'd5, 32'd1);
    fwdA_i = 2'b11; fwdB_i = 2'b11; exmem_data_i = 32'd100; memwb_data_i = 32'd200;
    issue_alu("fwd_rsvd", 32'd6, 32'd1, 5'd3);
    set_ops(2'b00, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    issue_alu("add_wrap", 32'd0, 32'd1, 5'd3);

    set_ops(2'b10, 32'h18, 1'b0, 32'd6, 32'd7);
    valid_i = 1'b0;
    #1;
    check("bubble_busy", {31'b0, busy_o}, 32'd0);
    step();
    check("bubble_state", {30'b0, dut.u_mul_iter.state_o}, {30'b0, ST_IDLE});

    set_ops(2'b10, 32'h18, 1'b0, 32'd6, 32'd7);
    issue_mul("mul_6x7", 32'd42, 32'd7, 1'b1);
    set_ops(2'b10, 32'h18, 1'b0, 32'h8000_0000, 32'd2);
    issue_mul("mul_ovf", 32'd0, 32'd2, 1'b0);
    set_ops(2'b10, 32'h18, 1'b0, 32'd3, 32'd3);
    issue_mul("mul_b2b", 32'd9, 32'd3, 1'b0);
    set_ops(2'b10, 32'h18, 1'b0, 32'd5, 32'd0);
    issue_mul("mul_zero", 32'd0, 32'd0, 1'b0);

    set_ops(2'b10, 32'h18, 1'b0, 32'd6, 32'd7);
    #1;
    check("abort_start_busy", {31'b0, busy_o}, 32'd1);
    for (int i = 0; i < 10; i++) step();
    rst_i = 1'b0;
    valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_state", {30'b0, dut.u_mul_iter.state_o}, {30'b0, ST_IDLE});
    set_ops(2'b10, 32'h20, 1'b0, 32'd20, 32'd22);
    issue_alu("add_after_abort", 32'd42, 32'd22, 5'd3);

    valid_i = 1'b0;
    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, consuming the ID/EX register outputs and feeding the EX/MEM register.
- Selects forwarded operands and computes single-cycle ALU results.
- Runs an iterative 32-cycle shift-add multiplier for R-type `mul`.
- Requests a pipeline stall while the multiply is in flight.

Parameters:
- DATA_W, 32, datapath width; the multiplier iteration count equals DATA_W.
- REG_W, 5, register-index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- valid_i  in  1  ID/EX holds a real instruction (0 = bubble).
- data1_i  in  DATA_W  rs value from ID/EX.
- data2_i  in  DATA_W  rt value from ID/EX.
- extend_i  in  DATA_W  sign/zero-extended immediate; bits [5:0] are funct.
- ALUSrc_i  in  1  1 selects extend_i as operand B.
- ALUOp_i  in  2  00 add, 01 sub, 10 R-type per funct, 11 or.
- RegDst_i  in  1  1 selects MUX1_i (rd), 0 selects MUX0_i (rt).
- MUX0_i  in  REG_W  rt index.
- MUX1_i  in  REG_W  rd index.
- fwdA_i  in  2  operand A source: 00 data1_i, 10 exmem_data_i, 01 memwb_data_i, 11 treated as 00.
- fwdB_i  in  2  operand B source, same encoding, applied to data2_i before the ALUSrc mux.
- exmem_data_i  in  DATA_W  EX/MEM forwarding value.
- memwb_data_i  in  DATA_W  MEM/WB forwarding value.
- result_o  out  DATA_W  ALU result or product.
- store_data_o  out  DATA_W  forwarded rt value, for sw.
- wreg_o  out  REG_W  destination register index.
- busy_o  out  1  stall request to PC, IF/ID and ID/EX (ID/EX must hold while 1).

Behaviour:
- Combinational path (state IDLE, non-mul):
  - A = fwdA mux; Bf = fwdB mux; B = ALUSrc_i ? extend_i : Bf.
  - ALUOp 00: A+B. 01: A-B. 11: A|B.
  - ALUOp 10 by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0), 011000 mul. Any other funct gives 0.
  - Add/sub wrap modulo 2^DATA_W; no overflow trap.
- Always-valid outputs: store_data_o = Bf; wreg_o = RegDst_i ? MUX1_i : MUX0_i.
- start = valid_i & ALUOp_i==10 & funct==011000 & state==IDLE.
- FSM states IDLE, MUL, DONE.
  - IDLE: on start, latch mcand=A, mplier=Bf, acc=0, cnt=0; go to MUL. Otherwise stay.
  - MUL: each cycle, if mplier[0] then acc+=mcand; then mcand<<=1, mplier>>=1, cnt++. When cnt==DATA_W-1, do the final step and go to DONE.
  - DONE: result_o = acc (low DATA_W bits of the product); go to IDLE unconditionally. start is ignored in DONE.
- busy_o = start | (state==MUL). It is combinational so ID/EX freezes in the start cycle; it is 0 in DONE.
- Latency:
  - Start in cycle 0, iterations in cycles 1..32, DONE (product on result_o) in cycle 33.
  - The mul instruction leaves EX at the clock edge ending cycle 33.
  - A back-to-back mul starts in cycle 34.
- Operand isolation: operands are latched at start, so changes on fwd*/data* during MUL have no effect.
- Non-mul instructions and bubbles: zero extra latency; busy_o stays 0.
- Bubble (valid_i=0): never starts a multiply; combinational outputs are don't-care downstream because ID/EX control is zero.
- Reset (rst_i=0 at an edge): state=IDLE, cnt=0, acc=0, mcand=0, mplier=0.
  - Reset mid-MUL aborts; busy_o is 0 in the cycle after reset unless start is reasserted.
- Simultaneous events: reset has priority over start and over iteration.
- Multiplier of 0: still takes the full 32 iterations (fixed latency).

Decomposition:
- Shared package: ALUOp encodings, funct constants (FUNCT_ADD/SUB/AND/OR/SLT/MUL), forwarding-select encodings, FSM state encoding.
- One natural sub-module: mul_iter (FSM, counter, shift-add datapath; ports start, a, b, busy, done, product).
- ex_stage keeps the muxes and the ALU.

Test Plan:
- ALUOp=10, funct add, A=7, B=5, fwd=00 → result_o=12, busy_o=0 in the same cycle.
- funct slt, A=0xFFFFFFFF, B=1 → result_o=1; funct sub, A=3, B=5 → 0xFFFFFFFE.
- fwdA=10, exmem_data_i=0x100, ALUSrc=1, extend_i=4, ALUOp=00 → 0x104; fwdB=01 → store_data_o=memwb_data_i.
- mul, A=6, B=7 → busy_o=1 in cycles 0..32, result_o=42 in cycle 33 with busy_o=0. Toggle data1_i during MUL → result still 42.
- mul, A=0x80000000, B=2 → result_o=0 (low bits). A back-to-back second mul (3×3) starts in cycle 34 → result_o=9 in cycle 67.
- rst_i=0 in cycle 10 of a mul → state IDLE, busy_o=0 next cycle with valid_i=0. A following add executes normally.
